// File: rtl/mem_bus_master_if.sv
// ============================================================================
// Module   : mem_bus_master_if
// Brief    : CPU request ports and single-port word memory bus for mem_bus_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_master_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_ack;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 err;
    logic                 busy;
    logic                 mem_on;
    logic                 mem_w;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err, busy,
               mem_on, mem_w, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
               mem_on, mem_w, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_master.sv
// ============================================================================
// Module   : mem_bus_master
// Brief    : Round-robin fetch/data initiator for a single-port word memory;
//            one access at a time, IDLE -> ACCESS -> DONE.
//            Optional macro MEM_BUS_MASTER_BOUND_CHECK_EN: out-of-range
//            addresses complete with ERR instead of reaching the bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_master #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_DEPTH = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mem_bus_master_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_last_d;
    logic                 r_sel_d;
    logic                 r_we;
    logic                 r_i_ack;
    logic                 r_d_ack;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic                 r_busy;
    logic                 r_mem_on;
    logic                 r_mem_w;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;

    logic                 w_grant;
    logic                 w_gnt_d;
    logic                 w_oob;
    logic                 w_store;
    logic [WORD_SIZE-1:0] w_addr;

`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
    localparam logic [WORD_SIZE:0] c_depth = (WORD_SIZE+1)'(MEM_DEPTH);
    logic                 r_err;
`else
    if (MEM_DEPTH < 1) begin : g_depth_invalid
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Both requesting: the port not granted last time wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_d     = 1'b0;
        w_oob       = 1'b0;
        w_addr      = bus.i_addr;
        w_store     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    w_grant = 1'b1;
                    w_gnt_d = bus.d_req && (!bus.i_req || !r_last_d);
                    w_addr  = w_gnt_d ? bus.d_addr : bus.i_addr;
                    w_store = w_gnt_d && bus.d_we;
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
                    w_oob   = ({1'b0, w_addr} >= c_depth);
`endif
                    w_state_nxt = w_oob ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d    <= 1'b0;
            r_sel_d     <= 1'b0;
            r_we        <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_busy      <= 1'b0;
            r_mem_on    <= 1'b0;
            r_mem_w     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_sel_d     <= w_gnt_d;
                        r_we        <= w_store;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_gnt_d ? bus.d_wdata : '0;
                        if (w_oob) begin
                            // Rejected access: complete immediately, bus stays quiet.
                            r_i_ack <= !w_gnt_d;
                            r_d_ack <= w_gnt_d;
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
                            r_err   <= 1'b1;
`endif
                            if (!w_gnt_d) begin
                                r_i_rdata <= '0;
                            end else if (!w_store) begin
                                r_d_rdata <= '0;
                            end
                        end else begin
                            r_mem_on <= 1'b1;
                            r_mem_w  <= w_store;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_mem_on <= 1'b0;
                    r_mem_w  <= 1'b0;
                    r_i_ack  <= !r_sel_d;
                    r_d_ack  <= r_sel_d;
                    if (!r_we) begin
                        if (r_sel_d) begin
                            r_d_rdata <= bus.mem_rdata;
                        end else begin
                            r_i_rdata <= bus.mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_last_d <= r_sel_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = r_busy;
    assign bus.mem_on    = r_mem_on;
    assign bus.mem_w     = r_mem_w;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// Module   : tb_mem_bus_master
// Brief    : Directed and randomized transactions for mem_bus_master against a
//            transaction-level memory/arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_master;

    localparam int WS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_master_if #(.WORD_SIZE(WS)) bus ();

    mem_bus_master #(.WORD_SIZE(WS), .MEM_DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: preload port, write commits on the rising edge.
    logic [15:0] mem [0:31];
    logic        pl_en   = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_on && bus.mem_w) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = (bus.mem_on && !bus.mem_w) ? mem[bus.mem_addr[4:0]] : 16'hzzzz;

    // Reference model state
    logic [15:0] ref_mem [0:31];
    logic [15:0] exp_i_rdata = '0;
    logic [15:0] exp_d_rdata = '0;
    bit          last_d      = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit oob(input logic [15:0] a);
`ifdef MEM_BUS_MASTER_BOUND_CHECK_EN
        return a >= 16'd16;
`else
        return (a != a);
`endif
    endfunction

    function automatic bit pick(input bit ireq, input bit dreq, input bit last);
        if (ireq && dreq) return !last;
        return dreq;
    endfunction

    // One complete transaction for the expected winner; starts in an IDLE cycle.
    task automatic txn(input bit exp_d, input bit drop);
        logic [15:0] a;
        logic [15:0] wd;
        bit          we;
        bit          bad;
        a   = exp_d ? bus.d_addr : bus.i_addr;
        wd  = bus.d_wdata;
        we  = exp_d && bus.d_we;
        bad = oob(a);
        tick();
        check("busy_grant", 32'(bus.busy), 32'd1);
        if (!bad) begin
            check("mem_on_access", 32'(bus.mem_on), 32'd1);
            check("mem_w_access", 32'(bus.mem_w), 32'(we));
            check("mem_addr_access", 32'(bus.mem_addr), 32'(a));
            if (we) check("mem_wdata_access", 32'(bus.mem_wdata), 32'(wd));
            check("ack_early", 32'({bus.i_ack, bus.d_ack}), 32'd0);
            tick();
        end
        if (we) ref_mem[a[4:0]] = wd;
        else if (exp_d) exp_d_rdata = bad ? 16'h0 : ref_mem[a[4:0]];
        else exp_i_rdata = bad ? 16'h0 : ref_mem[a[4:0]];
        last_d = exp_d;
        check("i_ack_done", 32'(bus.i_ack), 32'(!exp_d));
        check("d_ack_done", 32'(bus.d_ack), 32'(exp_d));
        check("err_done", 32'(bus.err), 32'(bad));
        check("mem_on_done", 32'(bus.mem_on | bus.mem_w), 32'd0);
        check("i_rdata_done", 32'(bus.i_rdata), 32'(exp_i_rdata));
        check("d_rdata_done", 32'(bus.d_rdata), 32'(exp_d_rdata));
        if (drop) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_acks", 32'({bus.i_ack, bus.d_ack, bus.mem_on}), 32'd0);
        if (we) check("mem_commit", 32'(mem[a[4:0]]), 32'(ref_mem[a[4:0]]));
    endtask

    initial begin
        logic [1:0] r;
        bit         g;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Preload while held in reset
        pl_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pl_addr = 5'(i);
            pl_data = (i == 0) ? 16'h100B : (i == 3) ? 16'h0000 : 16'($urandom);
            ref_mem[i] = pl_data;
            tick();
        end
        pl_en = 1'b0;

        check("rst_acks", 32'({bus.i_ack, bus.d_ack, bus.err, bus.busy}), 32'd0);
        check("rst_mem_ctl", 32'({bus.mem_on, bus.mem_w}), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_i_rdata", 32'(bus.i_rdata), 32'd0);
        check("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch from address 0, then confirm the word is held
        bus.i_addr = 16'h0000; bus.i_req = 1'b1;
        txn(1'b0, 1'b1);
        tick();
        check("i_rdata_held", 32'(bus.i_rdata), 32'h100B);

        // Store 0xBEEF to 5, load it back
        bus.d_we = 1'b1; bus.d_addr = 16'd5; bus.d_wdata = 16'hBEEF; bus.d_req = 1'b1;
        txn(1'b1, 1'b1);
        bus.d_we = 1'b0; bus.d_req = 1'b1;
        txn(1'b1, 1'b1);
        check("load_beef", 32'(bus.d_rdata), 32'hBEEF);

        // Reset in the ACCESS cycle of a store to address 3
        bus.d_we = 1'b1; bus.d_addr = 16'd3; bus.d_wdata = 16'hAAAA; bus.d_req = 1'b1;
        tick();
        check("rst_mid_mem_w_before", 32'(bus.mem_w), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_async_drop", 32'({bus.mem_on, bus.mem_w}), 32'd0);
        @(posedge clk); #1;
        check("rst_mid_no_commit", 32'(mem[3]), 32'h0000);
        check("rst_mid_no_ack", 32'({bus.d_ack, bus.i_ack, bus.busy}), 32'd0);
        check("rst_mid_rdata", 32'({bus.i_rdata, bus.d_rdata}), 32'd0);
        check("rst_mid_mem_addr", 32'(bus.mem_addr), 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        exp_i_rdata = '0; exp_d_rdata = '0; last_d = 1'b0;
        rst_n = 1'b1;
        tick();

        // Both requesting for four transactions: D, I, D, I
        bus.i_addr = 16'd1; bus.d_addr = 16'd2; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = pick(1'b1, 1'b1, last_d);
            check("rr_order", 32'(g), 32'((k % 2) == 0));
            txn(g, k == 3);
        end

        // Out-of-range load
        bus.d_addr = 16'h0010; bus.d_we = 1'b0; bus.d_req = 1'b1;
        txn(1'b1, 1'b1);

        // REQ held one cycle past ACK starts a second transaction
        bus.d_addr = 16'd7; bus.d_req = 1'b1;
        txn(1'b1, 1'b0);
        txn(1'b1, 1'b1);

        // Randomized mix
        for (int k = 0; k < 24; k++) begin
            r = 2'($urandom_range(1, 3));
            bus.i_addr  = 16'($urandom_range(0, 17));
            bus.d_addr  = 16'($urandom_range(0, 17));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = 16'($urandom);
            bus.i_req   = r[0];
            bus.d_req   = r[1];
            txn(pick(r[0], r[1], last_d), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the single-port word memory bus (W/ON/ADDR/DATA_IN/DATA_OUT).
- Accepts instruction-fetch and data load/store requests from the CPU datapath over REQ/ACK handshakes.
- Arbitrates between the two requesters and sequences exactly one memory access at a time.
- Returns captured read data to the requester.

Parameters:
- WORD_SIZE, 16, width of data and address words.
- MEM_DEPTH, 16, number of implemented memory words; used only by the optional bound check.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- I_REQ  input  1  fetch request; held high with I_ADDR stable until I_ACK.
- I_ADDR  input  WORD_SIZE  fetch address.
- I_ACK  output  1  one-cycle completion pulse for the fetch port.
- I_RDATA  output  WORD_SIZE  fetched word; valid in the I_ACK cycle and held until the next fetch completes.
- D_REQ  input  1  data request; held high with D_WE, D_ADDR and D_WDATA stable until D_ACK.
- D_WE  input  1  1 = store, 0 = load.
- D_ADDR  input  WORD_SIZE  data address.
- D_WDATA  input  WORD_SIZE  store data.
- D_ACK  output  1  one-cycle completion pulse for the data port.
- D_RDATA  output  WORD_SIZE  load result; valid in the D_ACK cycle and held until the next data load completes.
- ERR  output  1  address error, pulses with ACK (optional feature only).
- BUSY  output  1  high whenever state is not IDLE.
- MEM_ON  output  1  memory enable.
- MEM_W  output  1  memory write strobe.
- MEM_ADDR  output  WORD_SIZE  memory address.
- MEM_WDATA  output  WORD_SIZE  drives memory DATA_IN.
- MEM_RDATA  input  WORD_SIZE  from memory DATA_OUT; combinational and Z unless ON=1 and W=0.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE; all outputs 0, including I_RDATA and D_RDATA.
  - Last-grant flag = FETCH, so data wins the first tie.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Sample I_REQ and D_REQ at the clock edge.
  - If only one is high, grant it. If both are high, grant the port not granted last (round-robin). If neither, stay in IDLE.
  - On grant: latch op, address and write data; load MEM_ADDR and MEM_WDATA; set MEM_ON=1; set MEM_W=1 for a store, else 0; go to ACCESS.
- ACCESS (exactly one cycle):
  - Memory bus is stable for the whole cycle.
  - Store: memory commits at the closing edge.
  - Load/fetch: MEM_RDATA is captured into the granted port's RDATA register at the closing edge.
  - At that edge: MEM_ON=0, MEM_W=0, MEM_ADDR and MEM_WDATA unchanged; go to DONE.
- DONE (one cycle):
  - Granted port's ACK=1; update the last-grant flag; next state IDLE.
  - Requester must drop REQ at the edge ending the ACK cycle. A REQ still high in the following IDLE cycle is a new transaction.
- Latency and throughput:
  - ACK appears 3 edges after the edge at which REQ is first sampled high in IDLE.
  - Maximum throughput is 1 transaction per 3 cycles.
- Invariants:
  - MEM_W=1 only when MEM_ON=1.
  - MEM_ON is high only in ACCESS.
  - Never more than one ACK high.
  - The non-granted RDATA register never changes.
- A request arriving while BUSY waits, unaffected, and is sampled at the next IDLE.
- A store's D_RDATA is left unchanged.
- Reset mid-operation: MEM_ON and MEM_W drop immediately (asynchronously); no write commits at the next edge; no ACK is issued; the state returns to IDLE.
- Width rule: addresses pass through unmodified at full WORD_SIZE.

Optional Feature:
- Macro: MEM_BUS_MASTER_BOUND_CHECK_EN.
- Enabled:
  - In IDLE, a granted address >= MEM_DEPTH skips ACCESS and goes directly to DONE.
  - MEM_ON stays 0, so no bus activity.
  - ACK=1 and ERR=1 for that one cycle.
  - For a load/fetch, the granted port's RDATA is set to 0.
  - Latency is 2 edges.
- Disabled: ERR is tied to 0; every address is passed to the memory bus.

Test Plan:
- Fetch from I_ADDR=0 with mem[0]=0x100B -> MEM_ON=1, MEM_W=0, MEM_ADDR=0 for one cycle; I_ACK pulses 3 edges after sampling; I_RDATA=0x100B and held afterwards.
- Store D_ADDR=5, D_WDATA=0xBEEF, then load D_ADDR=5 -> exactly one cycle with MEM_W=1 and MEM_ADDR=5; load returns D_RDATA=0xBEEF; I_RDATA unchanged.
- I_REQ and D_REQ both held high for 4 transactions after reset -> grants in order D, I, D, I; never two ACKs in one cycle; BUSY low only in the IDLE cycles between transactions.
- Assert RST_N=0 in the ACCESS cycle of a store to addr 3 (old value 0x0000) -> MEM_W falls before the edge; mem[3] still 0x0000; no D_ACK; all outputs 0.
- Load D_ADDR=0x0010 with MEM_DEPTH=16:
  - Macro defined: no MEM_ON pulse; D_ACK=1 and ERR=1 after 2 edges; D_RDATA=0.
  - Macro undefined: normal access with MEM_ADDR=0x0010; ERR stays 0.
- REQ left high for one extra cycle after ACK -> second identical transaction starts from IDLE; second ACK 3 edges later.
